// File: rtl/pc_seq_pkg.sv
// pc_seq shared types: FSM states, redirect sources
// and the alignment helper used by the sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_ISSUE,
    ST_WAIT_CMT,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_JUMP,
    SRC_MRET,
    SRC_TRAP,
    SRC_HALT
  } src_e;

  localparam int ALIGN_BITS_DEF = 2;

  function automatic int align_bits(input int ilen);
    return $clog2(ilen);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// IFU fetch handshake plus WBU commit bus.
// master = PC sequencer, slave = core side.
interface pc_seq_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_o;
  logic            pc_valid;
  logic            pc_ready;
  logic            commit_valid;
  logic            commit_jump;
  logic [XLEN-1:0] commit_target;
  logic            commit_trap;
  logic [XLEN-1:0] trap_vec;
  logic            commit_mret;
  logic [XLEN-1:0] mepc;
  logic            commit_halt;

  modport master (
    output pc_o, pc_valid,
    input  pc_ready, commit_valid,
    input  commit_jump, commit_target,
    input  commit_trap, trap_vec,
    input  commit_mret, mepc,
    input  commit_halt
  );

  modport slave (
    input  pc_o, pc_valid,
    output pc_ready, commit_valid,
    output commit_jump, commit_target,
    output commit_trap, trap_vec,
    output commit_mret, mepc,
    output commit_halt
  );
endinterface

// File: rtl/pc_seq_next_sel.sv
// Next-PC priority mux with misalign detection
// on the mret/jump redirect targets.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_halt,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_tgt,
  output src_e            o_src,
  output logic            o_misalign_hit
);
  localparam logic [XLEN-1:0] LOW_MASK =
    XLEN'(ILEN_BYTES - 1);

  logic [XLEN-1:0] w_tvec_al;

  assign w_tvec_al = i_trap_vec & ~LOW_MASK;

  always_comb begin
    o_next_pc      = i_pc + XLEN'(ILEN_BYTES);
    o_tgt          = i_mret ? i_mepc : i_target;
    o_src          = SRC_SEQ;
    o_misalign_hit = 1'b0;
    if (i_halt) begin
      o_next_pc = i_pc;
      o_src     = SRC_HALT;
    end else if (i_trap) begin
      o_next_pc = w_tvec_al;
      o_src     = SRC_TRAP;
    end else if (i_mret || i_jump) begin
      o_src = i_mret ? SRC_MRET : SRC_JUMP;
      // Misaligned redirects fall into the trap vector.
      if ((o_tgt & LOW_MASK) != '0) begin
        o_next_pc      = w_tvec_al;
        o_misalign_hit = 1'b1;
      end else begin
        o_next_pc = o_tgt;
      end
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Architectural PC sequencer: issues PC to the IFU,
// waits for commit, selects next PC, counts instret.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter int          ILEN_BYTES = 4,
  parameter int          CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_seq_if.master         bus,
  output logic             misalign,
  output logic [XLEN-1:0]  bad_addr,
  output logic             halted,
  output logic             proto_err,
  output logic [CNT_W-1:0] instret
);
  state_e          r_state;
  state_e          w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_tgt;
  src_e            w_src;
  logic            w_hit;
  logic            w_commit;
  logic            w_count;

  pc_next_sel #(
    .XLEN       (XLEN),
    .ILEN_BYTES (ILEN_BYTES)
  ) u_sel (
    .i_pc           (r_pc),
    .i_jump         (bus.commit_jump),
    .i_target       (bus.commit_target),
    .i_trap         (bus.commit_trap),
    .i_trap_vec     (bus.trap_vec),
    .i_mret         (bus.commit_mret),
    .i_mepc         (bus.mepc),
    .i_halt         (bus.commit_halt),
    .o_next_pc      (w_next_pc),
    .o_tgt          (w_tgt),
    .o_src          (w_src),
    .o_misalign_hit (w_hit)
  );

  assign bus.pc_o = r_pc;
  assign w_commit = bus.commit_valid &&
                    (r_state == ST_WAIT_CMT);
  assign w_count  = w_commit &&
                    (w_src != SRC_TRAP) && !w_hit;

  always_comb begin
    w_state_nx   = r_state;
    bus.pc_valid = 1'b0;
    halted       = 1'b0;
    unique case (r_state)
      ST_BOOT: w_state_nx = ST_ISSUE;
      ST_ISSUE: begin
        bus.pc_valid = 1'b1;
        if (bus.pc_ready) w_state_nx = ST_WAIT_CMT;
      end
      ST_WAIT_CMT: begin
        if (bus.commit_valid)
          w_state_nx = bus.commit_halt ? ST_HALT
                                       : ST_ISSUE;
      end
      ST_HALT: halted = 1'b1;
      default: w_state_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= XLEN'(RESET_VEC);
      misalign  <= 1'b0;
      bad_addr  <= '0;
      proto_err <= 1'b0;
      instret   <= '0;
    end else begin
      misalign <= w_commit && w_hit;
      if (w_commit) r_pc <= w_next_pc;
      if (w_commit && w_hit) bad_addr <= w_tgt;
      if (w_count) instret <= instret + 1'b1;
      if (bus.commit_valid && r_state != ST_WAIT_CMT)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios
// plus randomized commits against a behavioural model.
module tb_pc_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        misalign;
  logic [31:0] bad_addr;
  logic        halted;
  logic        proto_err;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [63:0] m_ir;
  logic [31:0] m_bad;
  logic        m_halt;

  pc_seq_if #(.XLEN(32)) ifc ();

  pc_seq #(
    .XLEN       (32),
    .RESET_VEC  (32'h8000_0000),
    .ILEN_BYTES (4),
    .CNT_W      (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.master),
    .misalign  (misalign),
    .bad_addr  (bad_addr),
    .halted    (halted),
    .proto_err (proto_err),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  function automatic void clr_bus();
    ifc.pc_ready      = 1'b0;
    ifc.commit_valid  = 1'b0;
    ifc.commit_jump   = 1'b0;
    ifc.commit_target = '0;
    ifc.commit_trap   = 1'b0;
    ifc.commit_mret   = 1'b0;
    ifc.mepc          = '0;
    ifc.commit_halt   = 1'b0;
  endfunction

  // Architectural meaning of a commit, from the rules.
  function automatic logic model_step(
    logic j, logic [31:0] t, logic tr,
    logic [31:0] tv, logic mr, logic [31:0] me,
    logic h);
    logic [31:0] tgt;
    logic [31:0] tva;
    tva = tv - (tv % 32'd4);
    tgt = mr ? me : t;
    if (h) begin
      m_ir++;
      m_halt = 1'b1;
    end else if (tr) begin
      m_pc = tva;
    end else if (mr || j) begin
      if (tgt % 32'd4 != 0) begin
        m_bad = tgt;
        m_pc  = tva;
        return 1'b1;
      end
      m_pc = tgt;
      m_ir++;
    end else begin
      m_pc = m_pc + 32'd4;
      m_ir++;
    end
    return 1'b0;
  endfunction

  task automatic do_commit(
    input  logic j, input logic [31:0] t,
    input  logic tr, input logic [31:0] tv,
    input  logic mr, input logic [31:0] me,
    input  logic h,
    input  int rdy_dly, input int cmt_dly,
    output logic to, output logic mis_obs,
    output logic mis_exp);
    int n;
    n = 0;
    to = 1'b0;
    mis_obs = 1'b0;
    mis_exp = 1'b0;
    while (!ifc.pc_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.pc_valid) begin
      to = 1'b1;
      return;
    end
    repeat (rdy_dly) @(negedge clk);
    ifc.pc_ready = 1'b1;
    @(negedge clk);
    ifc.pc_ready = 1'b0;
    repeat (cmt_dly) begin
      ifc.pc_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ifc.pc_ready      = 1'b0;
    ifc.commit_jump   = j;
    ifc.commit_target = t;
    ifc.commit_trap   = tr;
    ifc.trap_vec      = tv;
    ifc.commit_mret   = mr;
    ifc.mepc          = me;
    ifc.commit_halt   = h;
    ifc.commit_valid  = 1'b1;
    @(negedge clk);
    mis_obs = misalign;
    clr_bus();
    mis_exp = model_step(j, t, tr, tv, mr, me, h);
  endtask

  task automatic test_reset();
    clr_bus();
    ifc.trap_vec = 32'h8000_1000;
    rst_n = 1'b0;
    m_pc = 32'h8000_0000;
    m_ir = '0;
    m_bad = '0;
    m_halt = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.pc_o !== 32'h8000_0000 ||
        ifc.pc_valid !== 1'b0 || misalign !== 1'b0 ||
        bad_addr !== '0 || halted !== 1'b0 ||
        proto_err !== 1'b0 || instret !== '0) begin
      errors++;
      $display("FAIL reset pc=%h v=%b m=%b ba=%h h=%b pe=%b ir=%0d",
               ifc.pc_o, ifc.pc_valid, misalign, bad_addr,
               halted, proto_err, instret);
    end
    rst_n = 1'b1;
    checks++;
    if (ifc.pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_valid got %b want 0", ifc.pc_valid);
    end
    @(negedge clk);
    checks++;
    if (ifc.pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL boot_issue got %b want 1", ifc.pc_valid);
    end
  endtask

  task automatic test_seq();
    logic to, mo, me;
    for (int i = 0; i < 3; i++) begin
      do_commit(0, 0, 0, 32'h8000_1000, 0, 0, 0,
                0, 0, to, mo, me);
      checks++;
      if (to || ifc.pc_o !== m_pc ||
          ifc.pc_o !== 32'h8000_0004 + 32'(i * 4)) begin
        errors++;
        $display("FAIL seq%0d pc got %h want %h to=%b",
                 i, ifc.pc_o, m_pc, to);
      end
    end
    checks++;
    if (instret !== 64'd3) begin
      errors++;
      $display("FAIL seq_instret got %0d want 3", instret);
    end
  endtask

  task automatic test_jump();
    logic to, mo, me;
    logic [63:0] ir0;
    ir0 = m_ir;
    do_commit(1, 32'h8000_0100, 0, 32'h8000_1000, 0, 0, 0,
              0, 0, to, mo, me);
    checks++;
    if (to || ifc.pc_o !== 32'h8000_0100 || mo !== 1'b0) begin
      errors++;
      $display("FAIL jump_ok pc got %h want 80000100 mis=%b",
               ifc.pc_o, mo);
    end
    do_commit(1, 32'h8000_0102, 0, 32'h8000_1000, 0, 0, 0,
              1, 0, to, mo, me);
    checks++;
    if (to || mo !== 1'b1 || bad_addr !== 32'h8000_0102 ||
        ifc.pc_o !== 32'h8000_1000) begin
      errors++;
      $display("FAIL jump_mis mis=%b ba=%h pc=%h want 1 80000102 80001000",
               mo, bad_addr, ifc.pc_o);
    end
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0 || bad_addr !== 32'h8000_0102) begin
      errors++;
      $display("FAIL mis_pulse mis=%b ba=%h want 0 80000102",
               misalign, bad_addr);
    end
    checks++;
    if (instret !== ir0 + 64'd1) begin
      errors++;
      $display("FAIL jump_instret got %0d want %0d",
               instret, ir0 + 64'd1);
    end
  endtask

  task automatic test_trap_prio();
    logic to, mo, me;
    logic [63:0] ir0;
    ir0 = m_ir;
    do_commit(1, 32'h8000_0202, 1, 32'h8000_1003, 1,
              32'h8000_0041, 0, 0, 1, to, mo, me);
    checks++;
    if (to || ifc.pc_o !== 32'h8000_1000 || mo !== 1'b0 ||
        instret !== ir0) begin
      errors++;
      $display("FAIL trap_prio pc=%h mis=%b ir=%0d want 80001000 0 %0d",
               ifc.pc_o, mo, instret, ir0);
    end
    do_commit(0, 0, 0, 32'h8000_1000, 1, 32'h8000_0040, 0,
              0, 0, to, mo, me);
    checks++;
    if (to || ifc.pc_o !== 32'h8000_0040 || mo !== 1'b0) begin
      errors++;
      $display("FAIL mret pc got %h want 80000040", ifc.pc_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    logic to, mo, me;
    pc0 = m_pc;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.pc_valid !== 1'b1 || ifc.pc_o !== pc0) begin
        errors++;
        $display("FAIL stall%0d v=%b pc=%h want 1 %h",
                 i, ifc.pc_valid, ifc.pc_o, pc0);
      end
      @(negedge clk);
    end
    ifc.commit_valid = 1'b1;
    ifc.commit_jump  = 1'b1;
    ifc.commit_target = 32'h8000_0300;
    @(negedge clk);
    clr_bus();
    checks++;
    if (proto_err !== 1'b1 || ifc.pc_o !== pc0 ||
        ifc.pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL proto_issue pe=%b pc=%h v=%b want 1 %h 1",
               proto_err, ifc.pc_o, ifc.pc_valid, pc0);
    end
    do_commit(0, 0, 0, 32'h8000_1000, 0, 0, 0,
              0, 0, to, mo, me);
    checks++;
    if (to || ifc.pc_o !== pc0 + 32'd4) begin
      errors++;
      $display("FAIL post_stall pc got %h want %h",
               ifc.pc_o, pc0 + 32'd4);
    end
  endtask

  task automatic test_wrap();
    logic to, mo, me;
    do_commit(1, 32'hFFFF_FFFC, 0, 32'h8000_1000, 0, 0, 0,
              0, 0, to, mo, me);
    do_commit(0, 0, 0, 32'h8000_1000, 0, 0, 0,
              0, 0, to, mo, me);
    checks++;
    if (to || ifc.pc_o !== 32'h0000_0000 || mo !== 1'b0) begin
      errors++;
      $display("FAIL wrap pc=%h mis=%b want 00000000 0",
               ifc.pc_o, mo);
    end
  endtask

  task automatic test_random();
    logic to, mo, me;
    logic j, tr, mr;
    logic [31:0] t, tv, mp;
    int r;
    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 9));
      j  = (r >= 2 && r <= 5);
      mr = (r == 1 || r == 5);
      tr = (r == 0);
      t  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      mp = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      tv = 32'h8000_1000 | ($urandom & 32'h0000_00FF);
      if ($urandom_range(0, 1) == 1) t  = t & ~32'd3;
      if ($urandom_range(0, 1) == 1) mp = mp & ~32'd3;
      do_commit(j, t, tr, tv, mr, mp, 0,
                int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), to, mo, me);
      checks++;
      if (to || ifc.pc_o !== m_pc || mo !== me ||
          instret !== m_ir || bad_addr !== m_bad) begin
        errors++;
        $display("FAIL rand%0d pc=%h/%h mis=%b/%b ir=%0d/%0d ba=%h/%h to=%b",
                 i, ifc.pc_o, m_pc, mo, me, instret, m_ir,
                 bad_addr, m_bad, to);
      end
    end
  endtask

  task automatic test_halt();
    logic to, mo, me;
    logic [63:0] ir0;
    do_commit(1, 32'h8000_0020, 0, 32'h8000_1000, 0, 0, 0,
              0, 0, to, mo, me);
    ir0 = m_ir;
    do_commit(0, 0, 0, 32'h8000_1000, 0, 0, 1,
              0, 0, to, mo, me);
    checks++;
    if (to || halted !== 1'b1 || ifc.pc_o !== 32'h8000_0020 ||
        instret !== ir0 + 64'd1 || ifc.pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt h=%b pc=%h ir=%0d v=%b want 1 80000020 %0d 0",
               halted, ifc.pc_o, instret, ifc.pc_valid,
               ir0 + 64'd1);
    end
    ifc.commit_valid = 1'b1;
    ifc.pc_ready     = 1'b1;
    repeat (3) @(negedge clk);
    clr_bus();
    checks++;
    if (proto_err !== 1'b1 || halted !== 1'b1 ||
        ifc.pc_o !== 32'h8000_0020 ||
        instret !== ir0 + 64'd1) begin
      errors++;
      $display("FAIL halt_ignore pe=%b h=%b pc=%h ir=%0d",
               proto_err, halted, ifc.pc_o, instret);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.pc_o !== 32'h8000_0000 || halted !== 1'b0 ||
        proto_err !== 1'b0 || misalign !== 1'b0 ||
        bad_addr !== '0 || instret !== '0 ||
        ifc.pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst pc=%h h=%b pe=%b ir=%0d ba=%h",
               ifc.pc_o, halted, proto_err, instret, bad_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_jump();
    test_trap_prio();
    test_stall();
    test_wrap();
    test_random();
    test_halt();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
